// File: rtl/des_key_schedule_if.sv
// Key-load request and subkey stream between the key register, the schedule and the round datapath.
// Latency: none; this only bundles wires.
// Backpressure: subkey_ready from the consumer stalls the subkey stream; start is ignored while busy.
interface des_key_schedule_if;
    logic [63:0] key_in;
    logic        decrypt;
    logic        start;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        done;
    logic        parity_err;

    // Requester side: loads keys and consumes subkeys.
    modport master (
        output key_in, decrypt, start, subkey_ready,
        input  busy, subkey_valid, subkey, round, done, parity_err
    );

    // Schedule side.
    modport slave (
        input  key_in, decrypt, start, subkey_ready,
        output busy, subkey_valid, subkey, round, done, parity_err
    );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC1 on start, then one PC2 subkey per round (K1..K16 or K16..K1).
// Latency: first subkey 1 cycle after accepted start, done 17 cycles after start with ready held high.
// Backpressure: subkey/round hold while subkey_ready is low; each stalled cycle adds one cycle.
module des_key_schedule #(
    parameter bit CHECK_PARITY = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    des_key_schedule_if.slave    ks
);

    // FIPS 46-3 tables, 1-based bit numbers.
    localparam int unsigned PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic {IDLE, GEN} state_t;

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dec_q, dec_d;
    logic        par_q, par_d;
    logic        done_q, done_d;
    logic [55:0] pc1_out;
    logic        two_step;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int m = 0; m < 56; m++) begin
            o[m] = k[6'(PC1_TBL[m] - 1)];
        end
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int m = 0; m < 48; m++) begin
            o[m] = cd[6'(PC2_TBL[m] - 1)];
        end
        return o;
    endfunction

    // Bit 1 sits at index 0, so a FIPS left rotate moves bits toward index 0.
    function automatic logic [27:0] rot(input logic [27:0] x, input logic left, input logic two);
        logic [27:0] r;
        if (left) begin
            r = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
        end else begin
            r = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
        end
        return r;
    endfunction

    // Shift table entry S[i] is 1 for i = 1, 2, 9, 16 and 2 otherwise.
    function automatic logic shift_is_two(input logic [4:0] i);
        return !(i == 5'd1 || i == 5'd2 || i == 5'd9 || i == 5'd16);
    endfunction

    // A byte with an even number of ones violates DES odd parity.
    function automatic logic parity_bad(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int j = 0; j < 8; j++) begin
            bad = bad | ~(^k[8*j +: 8]);
        end
        return bad;
    endfunction

    // Next-state logic: key load in IDLE, one rotation per accepted subkey in GEN.
    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        dec_d    = dec_q;
        par_d    = par_q;
        done_d   = 1'b0;
        pc1_out  = pc1(ks.key_in);
        two_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (ks.start) begin
                    state_d = GEN;
                    cnt_d   = 4'd0;
                    dec_d   = ks.decrypt;
                    par_d   = CHECK_PARITY ? parity_bad(ks.key_in) : 1'b0;
                    // Decrypt starts at C16/D16, which equals the unrotated PC1 output.
                    if (ks.decrypt) begin
                        c_d = pc1_out[27:0];
                        d_d = pc1_out[55:28];
                    end else begin
                        c_d = rot(pc1_out[27:0], 1'b1, 1'b0);
                        d_d = rot(pc1_out[55:28], 1'b1, 1'b0);
                    end
                end
            end
            GEN: begin
                if (ks.subkey_ready) begin
                    if (cnt_q == 4'd15) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d    = cnt_q + 4'd1;
                        two_step = dec_q ? shift_is_two(5'd16 - {1'b0, cnt_q})
                                         : shift_is_two({1'b0, cnt_q} + 5'd2);
                        c_d      = rot(c_q, !dec_q, two_step);
                        d_d      = rot(d_q, !dec_q, two_step);
                    end
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any sequence without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end

    assign ks.busy         = (state_q == GEN);
    assign ks.subkey_valid = (state_q == GEN);
    assign ks.subkey       = (state_q == GEN) ? pc2({d_q, c_q}) : 48'd0;
    assign ks.round        = (state_q == GEN) ? (dec_q ? 4'd15 - cnt_q : cnt_q) : 4'd0;
    assign ks.done         = done_q;
    assign ks.parity_err   = par_q;

endmodule
